// File: rtl/lat_unroll_seq_if.sv
// lat_unroll_seq_if
// Bundle/handshake bundle between the fetch stage, the loop address table,
// the interpretor buffer and the loop-unroll dispatch sequencer.
//
// Handshake: a fetch bundle is transferred on a cycle where bundle_vld_in and
// ds_rdy_in are both high ("accept"). Neither side may make valid depend on
// ready. The sequencer never drives a ready of its own. It only shapes the
// lane mask and the fetch stall toward IF.
//
// Signals (sequencer view, modport slave):
//   pc_in[63:0]              in   4 lane PCs, lane0=[63:48] .. lane3=[15:0]
//   bundle_vld_in            in   fetch bundle valid
//   ds_rdy_in                in   interpretor accepts bundle this cycle
//   hit_in                   in   loop table hit on lane0
//   hit_fallthru_in[15:0]    in   fallthrough address of the hit entry
//   hit_num_insts_in[6:0]    in   loop body length
//   hit_max_unroll_in[6:0]   in   iteration limit
//   buf_pop_in[2:0]          in   instructions retired from interpretor buffer
//   mis_pred_in              in   mispredict flush
//   lbd_state_out[1:0]       out  sequencer state
//   inst_valid_out[3:0]      out  lane valid mask, bit3 = lane0
//   stll_ftch_out            out  stall fetch
//   fnsh_unrll_out           out  unroll-complete pulse
//   lp_err_out               out  body-length mismatch pulse
//   iter_cnt_out[6:0]        out  completed iterations
interface lat_unroll_seq_if;
  logic [63:0] pc_in;
  logic        bundle_vld_in;
  logic        ds_rdy_in;
  logic        hit_in;
  logic [15:0] hit_fallthru_in;
  logic [6:0]  hit_num_insts_in;
  logic [6:0]  hit_max_unroll_in;
  logic [2:0]  buf_pop_in;
  logic        mis_pred_in;
  logic [1:0]  lbd_state_out;
  logic [3:0]  inst_valid_out;
  logic        stll_ftch_out;
  logic        fnsh_unrll_out;
  logic        lp_err_out;
  logic [6:0]  iter_cnt_out;

  modport master (
    output pc_in, bundle_vld_in, ds_rdy_in, hit_in, hit_fallthru_in,
           hit_num_insts_in, hit_max_unroll_in, buf_pop_in, mis_pred_in,
    input  lbd_state_out, inst_valid_out, stll_ftch_out, fnsh_unrll_out,
           lp_err_out, iter_cnt_out
  );

  modport slave (
    input  pc_in, bundle_vld_in, ds_rdy_in, hit_in, hit_fallthru_in,
           hit_num_insts_in, hit_max_unroll_in, buf_pop_in, mis_pred_in,
    output lbd_state_out, inst_valid_out, stll_ftch_out, fnsh_unrll_out,
           lp_err_out, iter_cnt_out
  );
endinterface

// File: rtl/lat_unroll_seq.sv
// lat_unroll_seq
// Loop-unroll dispatch sequencer for the 4-wide front end. After the loop
// address table hits on lane0 of an accepted bundle, it counts body
// instructions and iterations, drives the per-lane valid mask and the fetch
// stall, and reports completion or a body-length mismatch.
//
// Ports:
//   clk   clock, all state on posedge
//   rst   synchronous active-low reset
//   bus   lat_unroll_seq_if.slave (see interface file for the signal list)
//
// Parameters:
//   BUF_DEPTH  interpretor buffer capacity in instructions (power of two, <= 64)
//
// Configuration macro:
//   LAT_SEQ_OVF_STALL_EN  when defined, a slot counter tracks buffer occupancy,
//                         drives stll_ftch_out and holds DRAIN until the
//                         buffer is empty. When undefined, buf_pop_in is
//                         ignored, stll_ftch_out is 0 and DRAIN lasts one cycle.
//
// State encoding is visible on lbd_state_out: 00 IDLE, 01 UNROLL, 10 DRAIN;
// 11 is unreachable and behaves as IDLE.
module lat_unroll_seq #(
  parameter int BUF_DEPTH = 64
) (
  input  logic           clk,
  input  logic           rst,
  lat_unroll_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_UNROLL = 2'b01,
    S_DRAIN  = 2'b10,
    S_UNUSED = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] fallthru_q, fallthru_d;
  logic [6:0]  num_insts_q, num_insts_d;
  logic [6:0]  max_unroll_q, max_unroll_d;
  logic [6:0]  body_q, body_d;
  logic [6:0]  iter_q, iter_d;
  logic        fnsh_q, fnsh_d;
  logic        err_q, err_d;
  logic        drain_done;

  logic        accept, in_idle, in_unroll, in_drain;
  logic        start, limit_pend, cnt_en;
  logic [15:0] ft_eff, end_pc;
  logic [3:0]  end_hit;
  logic        end_found;
  logic [1:0]  end_lane;
  logic [2:0]  n_valid;
  logic [6:0]  ni_eff, mu_eff, body_base, iter_base, body_sum, iter_inc;
  logic [3:0]  mask;

`ifdef LAT_SEQ_OVF_STALL_EN
  localparam logic [7:0] BUF_MAX  = 8'(BUF_DEPTH);
  localparam logic [7:0] STALL_TH = 8'(BUF_DEPTH - 4);
  logic [6:0] slot_q, slot_d;
  logic [2:0] slot_add;
  logic [7:0] slot_sum, slot_net, slot_clamp;
  logic       stll_q, stll_d;
`else
  logic       unused_pop;
  assign unused_pop = ^bus.buf_pop_in;
`endif

  // Bundle decode, end-lane search and counter arithmetic.
  always_comb begin
    accept    = bus.bundle_vld_in & bus.ds_rdy_in;
    in_unroll = (state_q == S_UNROLL);
    in_drain  = (state_q == S_DRAIN);
    in_idle   = !in_unroll && !in_drain;   // also covers the unused code

    // The hit bundle itself is handled with unroll rules using the table's
    // live outputs, since nothing has been captured yet.
    start     = in_idle & accept & bus.hit_in;
    ft_eff    = start ? bus.hit_fallthru_in   : fallthru_q;
    ni_eff    = start ? bus.hit_num_insts_in  : num_insts_q;
    mu_eff    = start ? bus.hit_max_unroll_in : max_unroll_q;
    body_base = start ? 7'd0 : body_q;
    iter_base = start ? 7'd0 : iter_q;

    // The last body instruction sits at fallthru - 1 (16-bit wrap).
    end_pc  = ft_eff - 16'd1;
    end_hit = {bus.pc_in[63:48] == end_pc, bus.pc_in[47:32] == end_pc,
               bus.pc_in[31:16] == end_pc, bus.pc_in[15:0]  == end_pc};
    end_found = |end_hit;
    if      (end_hit[3]) end_lane = 2'd0;
    else if (end_hit[2]) end_lane = 2'd1;
    else if (end_hit[1]) end_lane = 2'd2;
    else                 end_lane = 2'd3;

    n_valid = end_found ? ({1'b0, end_lane} + 3'd1) : 3'd4;

    // A hit that exhausts the limit in the hit bundle itself still enters
    // UNROLL; the next cycle sees iter == max and moves on to DRAIN without
    // counting further bundles.
    limit_pend = in_unroll & (iter_q == max_unroll_q);
    cnt_en     = accept & (start | (in_unroll & !limit_pend));
    body_sum   = body_base + {4'd0, n_valid};
    iter_inc   = iter_base + 7'd1;

    mask = 4'b1111;
    if ((start || in_unroll) && end_found)
      mask = 4'b1111 << (2'd3 - end_lane);
    bus.inst_valid_out = mask;
  end

`ifdef LAT_SEQ_OVF_STALL_EN
  // Buffer occupancy: instructions sent during unroll minus retirements,
  // saturating at both ends.
  always_comb begin
    slot_add   = (accept && (start || in_unroll)) ? n_valid : 3'd0;
    slot_sum   = {1'b0, slot_q} + {5'd0, slot_add};
    slot_net   = slot_sum - {5'd0, bus.buf_pop_in};
    slot_clamp = slot_net;
    if (slot_sum < {5'd0, bus.buf_pop_in}) slot_clamp = 8'd0;
    else if (slot_net > BUF_MAX)           slot_clamp = BUF_MAX;
    slot_d = bus.mis_pred_in ? 7'd0 : slot_clamp[6:0];
    // Downstream absorbs up to 4 more instructions after the stall is seen.
    stll_d = (state_d == S_UNROLL) && ({1'b0, slot_d} > STALL_TH);
    drain_done = (slot_q == 7'd0);
  end
  assign bus.stll_ftch_out = stll_q;
`else
  assign drain_done        = 1'b1;
  assign bus.stll_ftch_out = 1'b0;
`endif

  // Next-state logic. Priority: mispredict > length error > iteration limit.
  always_comb begin
    state_d      = in_idle ? S_IDLE : state_q;
    fallthru_d   = fallthru_q;
    num_insts_d  = num_insts_q;
    max_unroll_d = max_unroll_q;
    body_d       = body_q;
    iter_d       = iter_q;
    fnsh_d       = 1'b0;
    err_d        = 1'b0;

    if (bus.mis_pred_in) begin
      state_d = S_IDLE;
      body_d  = 7'd0;
      iter_d  = 7'd0;
    end else begin
      if (start) begin
        fallthru_d   = bus.hit_fallthru_in;
        num_insts_d  = bus.hit_num_insts_in;
        max_unroll_d = bus.hit_max_unroll_in;
        body_d       = 7'd0;
        iter_d       = 7'd0;
        state_d      = S_UNROLL;
      end
      if (limit_pend) begin
        state_d = S_DRAIN;
      end else if (cnt_en) begin
        body_d = body_sum;
        if (end_found) begin
          if (body_sum != ni_eff) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            iter_d = iter_inc;
            body_d = 7'd0;
            if (!start && (iter_inc == mu_eff)) state_d = S_DRAIN;
          end
        end
      end
      if (in_drain && drain_done) begin
        state_d = S_IDLE;
        fnsh_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      fallthru_q   <= 16'd0;
      num_insts_q  <= 7'd0;
      max_unroll_q <= 7'd0;
      body_q       <= 7'd0;
      iter_q       <= 7'd0;
      fnsh_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef LAT_SEQ_OVF_STALL_EN
      slot_q       <= 7'd0;
      stll_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fallthru_q   <= fallthru_d;
      num_insts_q  <= num_insts_d;
      max_unroll_q <= max_unroll_d;
      body_q       <= body_d;
      iter_q       <= iter_d;
      fnsh_q       <= fnsh_d;
      err_q        <= err_d;
`ifdef LAT_SEQ_OVF_STALL_EN
      slot_q       <= slot_d;
      stll_q       <= stll_d;
`endif
    end
  end

  assign bus.lbd_state_out  = state_q;
  assign bus.iter_cnt_out   = iter_q;
  assign bus.fnsh_unrll_out = fnsh_q;
  assign bus.lp_err_out     = err_q;

endmodule

// File: tb/tb_lat_unroll_seq.sv
// tb_lat_unroll_seq
// Self-checking bench for lat_unroll_seq: a table of mask vectors applied
// under backpressure, hand-written multi-cycle sequences, and randomized loop
// traffic compared every cycle against a behavioural model.
module tb_lat_unroll_seq;
  localparam int BUF = 64;
`ifdef LAT_SEQ_OVF_STALL_EN
  localparam logic STALL_ON = 1'b1;
`else
  localparam logic STALL_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lat_unroll_seq_if bus();
  lat_unroll_seq #(.BUF_DEPTH(BUF)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- types ----------------
  typedef struct {
    logic        r, v, d, h, mp;
    logic [15:0] ft;
    logic [6:0]  ni, mu;
    logic [2:0]  pop;
    logic [63:0] pc;
  } in_t;

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  mask;
  } tv_t;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];   // {state, iter, stll, fnsh, err}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_state = 0;   // 0 idle, 1 unroll, 2 drain
  logic [15:0] m_ft = 0;
  int m_ni = 0, m_mu = 0, m_body = 0, m_iter = 0, m_slot = 0;
  bit m_fnsh = 0, m_err = 0, m_stll = 0;
  bit m_counted = 0;
  int m_nv = 0;

  function automatic int end_lane(input logic [63:0] pc, input logic [15:0] ft);
    logic [15:0] tgt;
    tgt = ft - 16'd1;
    for (int i = 0; i < 4; i++)
      if (pc[63-16*i -: 16] == tgt) return i;
    return -1;
  endfunction

  function automatic logic [3:0] lane_mask(input int k);
    logic [3:0] m;
    m = 4'b0000;
    if (k < 0) return 4'b1111;
    for (int i = 0; i <= k; i++) m[3-i] = 1'b1;
    return m;
  endfunction

  function automatic logic [3:0] model_mask(input in_t x);
    bit start;
    start = (m_state == 0) && x.v && x.d && x.h;
    if (start) return lane_mask(end_lane(x.pc, x.ft));
    if (m_state == 1) return lane_mask(end_lane(x.pc, m_ft));
    return 4'b1111;
  endfunction

  task automatic model_update(input in_t x);
    bit acc, start, fn, er, drain_ok;
    int ns, k, nv, add;
    acc = x.v && x.d;
    fn = 0; er = 0; add = 0; m_counted = 0;
    if (!x.r) begin
      ns = 0; m_ft = 0; m_ni = 0; m_mu = 0; m_body = 0; m_iter = 0; m_slot = 0;
    end else if (x.mp) begin
      ns = 0; m_body = 0; m_iter = 0; m_slot = 0;
    end else begin
      ns = m_state;
      drain_ok = 1;
`ifdef LAT_SEQ_OVF_STALL_EN
      drain_ok = (m_slot == 0);
`endif
      start = (m_state == 0) && acc && x.h;
      if (start) begin
        m_ft = x.ft; m_ni = x.ni; m_mu = x.mu; m_body = 0; m_iter = 0; ns = 1;
      end
      if (start || m_state == 1) begin
        k  = end_lane(x.pc, m_ft);
        nv = (k < 0) ? 4 : k + 1;
        if (acc) add = nv;
        if (!start && m_iter == m_mu) ns = 2;
        else if (acc) begin
          m_counted = 1; m_nv = nv;
          m_body += nv;
          if (k >= 0) begin
            if (m_body != m_ni) begin er = 1; ns = 0; end
            else begin
              m_iter++; m_body = 0;
              if (m_iter == m_mu && !start) ns = 2;
            end
          end
        end
      end
`ifdef LAT_SEQ_OVF_STALL_EN
      m_slot = m_slot + add - int'(x.pop);
      if (m_slot < 0) m_slot = 0;
      if (m_slot > BUF) m_slot = BUF;
`endif
      if (m_state == 2 && drain_ok) begin ns = 0; fn = 1; end
    end
    m_state = ns;
    m_fnsh  = fn;
    m_err   = er;
    m_stll  = 0;
`ifdef LAT_SEQ_OVF_STALL_EN
    m_stll = (ns == 1) && (m_slot > BUF - 4);
`endif
  endtask

  // ---------------- driver ----------------
  function automatic in_t idle_in();
    in_t x;
    x.r = 1; x.v = 0; x.d = 0; x.h = 0; x.mp = 0;
    x.ft = 16'h0; x.ni = 7'd0; x.mu = 7'd0; x.pop = 3'd4; x.pc = 64'h0;
    return x;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input in_t x, input logic chk_m, input logic [3:0] m_exp);
    logic [11:0] e;
    rst                   = x.r;
    bus.bundle_vld_in     = x.v;
    bus.ds_rdy_in         = x.d;
    bus.hit_in            = x.h;
    bus.mis_pred_in       = x.mp;
    bus.hit_fallthru_in   = x.ft;
    bus.hit_num_insts_in  = x.ni;
    bus.hit_max_unroll_in = x.mu;
    bus.buf_pop_in        = x.pop;
    bus.pc_in             = x.pc;
    #1;
    check("mask_model", {28'd0, bus.inst_valid_out}, {28'd0, model_mask(x)});
    if (chk_m) check("mask_table", {28'd0, bus.inst_valid_out}, {28'd0, m_exp});
    @(posedge clk);
    model_update(x);
    exp_q.push_back({2'(m_state), 7'(m_iter), m_stll, m_fnsh, m_err});
    @(negedge clk);
    e = exp_q.pop_front();
    check("regs", {20'd0, bus.lbd_state_out, bus.iter_cnt_out, bus.stll_ftch_out,
                   bus.fnsh_unrll_out, bus.lp_err_out}, {20'd0, e});
  endtask

  function automatic logic [63:0] seq_pc(input logic [15:0] p);
    return {p, p + 16'd1, p + 16'd2, p + 16'd3};
  endfunction

  // ---------------- test ----------------
  tv_t tv[6];

  initial begin
    in_t x;
    logic [15:0] p;

    tv[0] = '{pc: {16'h0013, 16'h0000, 16'h0000, 16'h0000}, mask: 4'b1000};
    tv[1] = '{pc: {16'h0010, 16'h0013, 16'h0000, 16'h0000}, mask: 4'b1100};
    tv[2] = '{pc: {16'h0010, 16'h0011, 16'h0013, 16'h0013}, mask: 4'b1110};
    tv[3] = '{pc: {16'h0010, 16'h0011, 16'h0012, 16'h0013}, mask: 4'b1111};
    tv[4] = '{pc: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, mask: 4'b1111};
    tv[5] = '{pc: {16'h0013, 16'h0013, 16'h0013, 16'h0013}, mask: 4'b1000};

    rst = 1'b0;
    bus.bundle_vld_in = 0; bus.ds_rdy_in = 0; bus.hit_in = 0; bus.mis_pred_in = 0;
    bus.hit_fallthru_in = 0; bus.hit_num_insts_in = 0; bus.hit_max_unroll_in = 0;
    bus.buf_pop_in = 0; bus.pc_in = 0;
    @(negedge clk);

    // Reset values
    x = idle_in(); x.r = 0;
    step(x, 0, 4'h0);
    step(x, 0, 4'h0);
    check("rst_state", {30'd0, bus.lbd_state_out}, 32'd0);
    check("rst_mask",  {28'd0, bus.inst_valid_out}, 32'hF);
    check("rst_iter",  {25'd0, bus.iter_cnt_out}, 32'd0);
    check("rst_stll",  {31'd0, bus.stll_ftch_out}, 32'd0);
    check("rst_fnsh",  {31'd0, bus.fnsh_unrll_out}, 32'd0);
    check("rst_err",   {31'd0, bus.lp_err_out}, 32'd0);

    // Single-bundle body, two iterations
    x = idle_in(); x.v = 1; x.d = 1; x.h = 1; x.ft = 16'h0014; x.ni = 3; x.mu = 2;
    x.pc = seq_pc(16'h0011);
    step(x, 1, 4'b1110);
    check("s1_state_a", {30'd0, bus.lbd_state_out}, 32'd1);
    check("s1_iter_a",  {25'd0, bus.iter_cnt_out}, 32'd1);
    x.h = 0;
    step(x, 1, 4'b1110);
    check("s1_state_b", {30'd0, bus.lbd_state_out}, 32'd2);
    check("s1_iter_b",  {25'd0, bus.iter_cnt_out}, 32'd2);
    x = idle_in();
    step(x, 0, 4'h0);
    check("s1_fnsh",    {31'd0, bus.fnsh_unrll_out}, 32'd1);
    check("s1_idle",    {30'd0, bus.lbd_state_out}, 32'd0);
    step(x, 0, 4'h0);
    check("s1_fnsh_off", {31'd0, bus.fnsh_unrll_out}, 32'd0);

    // Reset while in DRAIN
    x = idle_in(); x.v = 1; x.d = 1; x.h = 1; x.ft = 16'h0014; x.ni = 3; x.mu = 2;
    x.pc = seq_pc(16'h0011); x.pop = 0;
    step(x, 0, 4'h0);
    x.h = 0;
    step(x, 0, 4'h0);
    check("s6_drain", {30'd0, bus.lbd_state_out}, 32'd2);
    x = idle_in(); x.r = 0; x.pop = 0;
    step(x, 0, 4'h0);
    check("s6_state", {30'd0, bus.lbd_state_out}, 32'd0);
    check("s6_mask",  {28'd0, bus.inst_valid_out}, 32'hF);
    check("s6_iter",  {25'd0, bus.iter_cnt_out}, 32'd0);
    check("s6_fnsh",  {31'd0, bus.fnsh_unrll_out}, 32'd0);
    check("s6_stll",  {31'd0, bus.stll_ftch_out}, 32'd0);
    x = idle_in();
    step(x, 0, 4'h0);
    check("s6_fnsh_after", {31'd0, bus.fnsh_unrll_out}, 32'd0);

    // Length mismatch: end lane reached with 4 of 5 instructions
    x = idle_in(); x.v = 1; x.d = 1; x.h = 1; x.ft = 16'h0014; x.ni = 5; x.mu = 4;
    x.pc = seq_pc(16'h0010);
    step(x, 1, 4'b1111);
    check("s3_err",   {31'd0, bus.lp_err_out}, 32'd1);
    check("s3_state", {30'd0, bus.lbd_state_out}, 32'd0);
    check("s3_iter",  {25'd0, bus.iter_cnt_out}, 32'd0);
    x = idle_in();
    step(x, 0, 4'h0);
    check("s3_err_off", {31'd0, bus.lp_err_out}, 32'd0);
    check("s3_nofnsh",  {31'd0, bus.fnsh_unrll_out}, 32'd0);

    // Mispredict at iter_cnt=3 together with an end lane
    x = idle_in(); x.v = 1; x.d = 1; x.h = 1; x.ft = 16'h0014; x.ni = 3; x.mu = 8;
    x.pc = seq_pc(16'h0011);
    step(x, 0, 4'h0);
    x.h = 0;
    step(x, 0, 4'h0);
    step(x, 0, 4'h0);
    check("s4_iter3", {25'd0, bus.iter_cnt_out}, 32'd3);
    x.mp = 1;
    step(x, 1, 4'b1110);
    check("s4_state", {30'd0, bus.lbd_state_out}, 32'd0);
    check("s4_iter",  {25'd0, bus.iter_cnt_out}, 32'd0);
    check("s4_fnsh",  {31'd0, bus.fnsh_unrll_out}, 32'd0);
    check("s4_err",   {31'd0, bus.lp_err_out}, 32'd0);
    x = idle_in();
    step(x, 0, 4'h0);
    check("s4_fnsh_b", {31'd0, bus.fnsh_unrll_out}, 32'd0);
    check("s4_err_b",  {31'd0, bus.lp_err_out}, 32'd0);

    // Backpressure: mask table applied with ds_rdy_in low, counters frozen
    x = idle_in(); x.v = 1; x.d = 1; x.h = 1; x.ft = 16'h0014; x.ni = 3; x.mu = 8;
    x.pc = seq_pc(16'h0011);
    step(x, 0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      x = idle_in(); x.v = 1; x.d = 0; x.pc = tv[i].pc; x.pop = 0;
      step(x, 1, tv[i].mask);
      check("s5_state", {30'd0, bus.lbd_state_out}, 32'd1);
      check("s5_iter",  {25'd0, bus.iter_cnt_out}, 32'd1);
    end
    x = idle_in(); x.mp = 1;
    step(x, 0, 4'h0);

    // Fallthrough 0x0000 wraps the end PC to 0xFFFF; max_unroll=1
    x = idle_in(); x.v = 1; x.d = 1; x.h = 1; x.ft = 16'h0000; x.ni = 2; x.mu = 1;
    x.pc = seq_pc(16'hFFFE);
    step(x, 1, 4'b1100);
    check("w_state_a", {30'd0, bus.lbd_state_out}, 32'd1);
    x = idle_in();
    step(x, 0, 4'h0);
    check("w_state_b", {30'd0, bus.lbd_state_out}, 32'd2);
    step(x, 0, 4'h0);
    check("w_state_c", {30'd0, bus.lbd_state_out}, 32'd0);
    check("w_fnsh",    {31'd0, bus.fnsh_unrll_out}, 32'd1);

    // Overflow stall: 64-instruction body, no pops
    p = 16'h00C0;
    for (int b = 0; b < 16; b++) begin
      x = idle_in(); x.v = 1; x.d = 1; x.h = (b == 0); x.ft = 16'h0100;
      x.ni = 64; x.mu = 2; x.pop = 0; x.pc = seq_pc(p);
      step(x, 0, 4'h0);
      p = p + 16'd4;
      if (b == 14) check("s2_stll_60", {31'd0, bus.stll_ftch_out}, 32'd0);
    end
    check("s2_stll_64", {31'd0, bus.stll_ftch_out}, {31'd0, STALL_ON});
    check("s2_state",   {30'd0, bus.lbd_state_out}, 32'd1);
    x = idle_in(); x.pop = 4;
    step(x, 0, 4'h0);
    check("s2_stll_drop", {31'd0, bus.stll_ftch_out}, 32'd0);
    x = idle_in(); x.mp = 1;
    step(x, 0, 4'h0);

    // Randomized loop traffic against the model
    for (int ep = 0; ep < 40; ep++) begin
      logic [15:0] ft, sp;
      int ni, mu, ni_drv;
      bit started;
      ft = 16'($urandom);
      ni = $urandom_range(1, 12);
      mu = $urandom_range(1, 5);
      ni_drv = ($urandom_range(0, 7) == 0) ? ni + 1 : ni;
      sp = ft - 16'(ni);
      p = sp;
      started = 0;
      for (int c = 0; c < 120; c++) begin
        x = idle_in();
        x.v = ($urandom_range(0, 7) != 0);
        x.d = ($urandom_range(0, 3) != 0);
        x.h = !started;
        x.ft = ft; x.ni = 7'(ni_drv); x.mu = 7'(mu);
        x.pop = 3'($urandom_range(0, 4));
        x.mp = ($urandom_range(0, 63) == 0);
        x.pc = seq_pc(p);
        step(x, 0, 4'h0);
        if (x.v && x.d && x.h && !x.mp) started = 1;
        if (m_counted) begin
          p = p + 16'(m_nv);
          if (p == ft) p = sp;
        end
        if (started && m_state == 0) break;
      end
      if (m_state != 0) begin
        x = idle_in(); x.mp = 1;
        step(x, 0, 4'h0);
      end
      x = idle_in();
      step(x, 0, 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
